io_interrupt_generator: RTL and testbench
=========================================

# io_interrupt_generator

Memory-mapped interrupt source block on the IO bus that produces the `interrupt_req` vector consumed by each core's control-register interrupt logic. It provides countdown timers and software-triggered interrupts. Each source can drive either a held level, acknowledged over the bus, or a one-cycle pulse, so both level- and edge-triggered receiver configurations are served. It sits at the SoC top level next to the other IO peripherals, and its output fans out to all cores.

## Interface
- `BASE_ADDRESS`, default `'hffff0200`: byte address of register 0; the block decodes 64 bytes.
- `NUM_INTERRUPTS`, default 16: width of `interrupt_req`.
- `NUM_TIMERS`, default 2 (1–4): timer i drives `interrupt_req[i]`; bits `NUM_TIMERS..NUM_INTERRUPTS-1` are software sources.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `io_write_en`  in  1  bus write strobe.
- `io_read_en`  in  1  bus read strobe.
- `io_address`  in  32  byte address, word aligned.
- `io_write_data`  in  32  write data.
- `io_read_data`  out  32  registered read data.
- `interrupt_req`  out  NUM_INTERRUPTS  registered interrupt lines to the cores.

## Operation
- **Register map.** Offsets are from `BASE_ADDRESS`. Timer t occupies 0x00+12t..0x08+12t.
- Per-timer registers:
  - LOAD (RW, 32 bits): reload value L.
  - CTRL (RW): bit0 `enable`, bit1 `periodic`, bit2 `pulse_mode`.
  - COUNT (RO): current count.
- Global registers:
  - 0x30 STATUS (RO): latched level bits for all sources.
  - 0x34 ACK (write-1-to-clear STATUS).
  - 0x38 SW_TRIGGER (WO): each 1 bit raises that software source.
  - 0x3C SW_MASKED (RO): `interrupt_req` snapshot.
- Other offsets read 0. Writes to read-only registers are ignored. Accesses outside the 64-byte window are ignored and leave `io_read_data` unchanged.
- **Timer states.**
  - IDLE: `enable`=0.
  - RUNNING: `enable`=1 and count≠0.
  - STALLED: `enable`=1 and count=0.
  - A CTRL write with `enable`=1 sets count to LOAD. RUNNING decrements the count by 1 each cycle.
- **Timer expiry.** Expiry is the 1→0 transition.
  - If `periodic`: count←LOAD in the same edge and the timer stays RUNNING.
  - Otherwise: `enable`←0 and the timer goes to IDLE.
  - If LOAD=0 when enabled, the timer enters STALLED and never expires.
  - A LOAD write while RUNNING does not change the current count. It takes effect at the next reload or enable.
- **Level mode** (`pulse_mode`=0).
  - Expiry sets STATUS[t], which holds `interrupt_req[t]` high until an ACK write with bit t set.
  - Expiry and ACK of the same bit in the same cycle: the set wins.
- **Pulse mode** (`pulse_mode`=1).
  - Expiry drives `interrupt_req[t]` high for exactly one cycle. STATUS[t] is not set.
  - Back-to-back expiries (L=1, periodic) hold the line high continuously.
- **Software sources.** The SW_TRIGGER write uses the same level/pulse rule. The pulse/level choice for software bits comes from bit2 of TIMER0 CTRL (global software mode). Bits `<NUM_TIMERS` in SW_TRIGGER are ignored.
- A CTRL write with `enable`=0 stops the timer and leaves STATUS untouched.
- Simultaneous `io_read_en` and `io_write_en` is illegal. An assertion checks it.

## Timing
- **Reset values:** all registers and counts 0, all timers IDLE, `interrupt_req`='0, `io_read_data`=0.
- **Read latency:** 1 cycle. `io_read_data` is valid the cycle after `io_read_en` and holds until the next read.
- **Write effect:** visible at the edge that samples `io_write_en`.
- **Timer latency:** CTRL enable written at edge E0 with LOAD=L. Expiry occurs at edge E0+L, and `interrupt_req[t]` is high from E0+L. A periodic timer then expires at E0+2L, E0+3L, and so on.
- **SW_TRIGGER latency:** written at edge E sets `interrupt_req` from E. In pulse mode it clears at E+1.
- **ACK latency:** ACK at edge E clears the line from E.
- **Async reset mid-count:** clears everything immediately. No expiry is reported after reset.

## Structure
- Register offsets go in the shared `defines` package as an `io_intgen_reg_t` enum. The CTRL bit layout goes there as the `intgen_ctrl_t` packed struct.
- Sub-module `interrupt_timer`, instantiated `NUM_TIMERS` times in a generate loop.
  - Owns LOAD, CTRL and count.
  - Outputs a one-cycle `expire` strobe plus `pulse_mode`.
- STATUS, the pulse registers, bus decode and the read mux live in the top module.

## Test plan
- LOAD=5, CTRL=1 (one-shot level) at E0 → `interrupt_req[0]` rises at E0+5. COUNT reads 0 and CTRL reads 0. After ACK=1 the line is low the next cycle and no further expiry occurs.
- LOAD=3, CTRL=7 on timer1 (periodic pulse) → `interrupt_req[1]` is a single-cycle pulse at E0+3, E0+6 and E0+9, with STATUS=0 throughout.
- LOAD=0, CTRL=1 → no interrupt over 100 cycles and COUNT stays 0. Then LOAD=2 followed by CTRL=1 → pulse/level at +2.
- Arrange expiry and ACK of the same bit in the same cycle → STATUS bit remains 1. Write LOAD=9 mid-count with L=4 → next expiry still at +4, following one at +9.
- SW_TRIGGER=`'h0000_0010` in level mode → `interrupt_req[4]` is held until ACK=`'h10`. Bits 0–1 written via SW_TRIGGER have no effect. A read of offset 0x3C returns the live vector one cycle after `io_read_en`.
- Assert reset while timer0 has count=2 → `interrupt_req`=0, all registers 0, and no interrupt after reset is released.

Source files
------------

// File: rtl/io_interrupt_generator_pkg.sv
// io_interrupt_generator_pkg: register map, CTRL layout and decode helpers for the interrupt generator
package io_interrupt_generator_pkg;

  typedef enum logic [5:0] {
    REG_T0_LOAD    = 6'h00,
    REG_T0_CTRL    = 6'h04,
    REG_T0_COUNT   = 6'h08,
    REG_T1_LOAD    = 6'h0C,
    REG_T1_CTRL    = 6'h10,
    REG_T1_COUNT   = 6'h14,
    REG_T2_LOAD    = 6'h18,
    REG_T2_CTRL    = 6'h1C,
    REG_T2_COUNT   = 6'h20,
    REG_T3_LOAD    = 6'h24,
    REG_T3_CTRL    = 6'h28,
    REG_T3_COUNT   = 6'h2C,
    REG_STATUS     = 6'h30,
    REG_ACK        = 6'h34,
    REG_SW_TRIGGER = 6'h38,
    REG_SW_MASKED  = 6'h3C
  } io_intgen_reg_t;

  typedef struct packed {
    logic pulse_mode;
    logic periodic;
    logic enable;
  } intgen_ctrl_t;

  localparam logic [5:0] TIMER_SPAN = 6'h30;

  function automatic logic [1:0] timer_sel(input logic [5:0] off);
    logic [5:0] q;
    q = off / 6'd12;
    return q[1:0];
  endfunction

  function automatic logic [5:0] timer_field(input logic [5:0] off);
    return off % 6'd12;
  endfunction

endpackage

// File: rtl/io_interrupt_generator_timer.sv
// interrupt_timer: countdown timer owning LOAD, CTRL and count, with a one-cycle expiry strobe
module interrupt_timer
  import io_interrupt_generator_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_we_i,
  input  logic         ctrl_we_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  load_o,
  output intgen_ctrl_t ctrl_o,
  output logic [31:0]  count_o,
  output logic         expire_o,
  output logic         pulse_mode_o
);

  logic [31:0]  load_q, load_d, count_q, count_d;
  intgen_ctrl_t ctrl_q, ctrl_d;

  // Next state: a CTRL write overrides a coincident expiry; reload uses the LOAD already latched
  always_comb begin
    expire_o = ctrl_q.enable && count_q == 32'd1 && !ctrl_we_i;
    load_d = load_we_i ? wdata_i : load_q;
    ctrl_d = ctrl_q;
    count_d = count_q;
    if (ctrl_we_i) begin
      ctrl_d = intgen_ctrl_t'(wdata_i[2:0]);
      count_d = wdata_i[0] ? load_q : count_q;
    end else if (expire_o) begin
      ctrl_d.enable = ctrl_q.periodic;
      count_d = ctrl_q.periodic ? load_q : 32'd0;
    end else if (ctrl_q.enable && count_q != 32'd0) begin
      count_d = count_q - 32'd1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q <= '0;
      ctrl_q <= '0;
      count_q <= '0;
    end else begin
      load_q <= load_d;
      ctrl_q <= ctrl_d;
      count_q <= count_d;
    end
  end

  assign load_o = load_q;
  assign ctrl_o = ctrl_q;
  assign count_o = count_q;
  assign pulse_mode_o = ctrl_q.pulse_mode;

endmodule

// File: rtl/io_interrupt_generator.sv
// io_interrupt_generator: memory-mapped timers and software interrupt sources driving interrupt_req
module io_interrupt_generator
  import io_interrupt_generator_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'hffff0200,
  parameter int          NUM_INTERRUPTS = 16,
  parameter int          NUM_TIMERS     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      io_write_en,
  input  logic                      io_read_en,
  input  logic [31:0]               io_address,
  input  logic [31:0]               io_write_data,
  output logic [31:0]               io_read_data,
  output logic [NUM_INTERRUPTS-1:0] interrupt_req
);

  localparam logic [NUM_INTERRUPTS-1:0] SW_MASK = {NUM_INTERRUPTS{1'b1}} << NUM_TIMERS;

  logic [5:0]                off, fld;
  logic [1:0]                sel;
  logic                      wr, rd, tmr_wr;
  logic [31:0]               load_v[4], count_v[4];
  intgen_ctrl_t              ctrl_v[4];
  logic [3:0]                expire, pmode;
  logic [NUM_INTERRUPTS-1:0] sw, ack, tim_exp, tim_pm, status_q, status_d, irq_q, irq_d;
  logic [31:0]               tim_rd, rdata_q, rdata_d;

  assign off = io_address[5:0];
  assign sel = timer_sel(off);
  assign fld = timer_field(off);
  assign wr = io_write_en && io_address[31:6] == BASE_ADDRESS[31:6];
  assign rd = io_read_en && io_address[31:6] == BASE_ADDRESS[31:6];
  assign tmr_wr = wr && off < TIMER_SPAN;

  genvar i;
  for (i = 0; i < 4; i++) begin : g_tmr
    if (i < NUM_TIMERS) begin : g_on
      interrupt_timer u_tmr (
        .clk          (clk),
        .reset        (reset),
        .load_we_i    (tmr_wr && sel == 2'(i) && fld == REG_T0_LOAD),
        .ctrl_we_i    (tmr_wr && sel == 2'(i) && fld == REG_T0_CTRL),
        .wdata_i      (io_write_data),
        .load_o       (load_v[i]),
        .ctrl_o       (ctrl_v[i]),
        .count_o      (count_v[i]),
        .expire_o     (expire[i]),
        .pulse_mode_o (pmode[i])
      );
    end else begin : g_off
      assign load_v[i] = '0;
      assign ctrl_v[i] = '0;
      assign count_v[i] = '0;
      assign expire[i] = 1'b0;
      assign pmode[i] = 1'b0;
    end
  end

  // Source combine: expiry/trigger set beats a same-cycle ACK; pulse bits live for one cycle only
  always_comb begin
    sw = (wr && off == REG_SW_TRIGGER) ? io_write_data[NUM_INTERRUPTS-1:0] & SW_MASK : '0;
    ack = (wr && off == REG_ACK) ? io_write_data[NUM_INTERRUPTS-1:0] : '0;
    tim_exp = NUM_INTERRUPTS'(expire);
    tim_pm = NUM_INTERRUPTS'(pmode);
    status_d = (status_q & ~ack) | (tim_exp & ~tim_pm) | (pmode[0] ? '0 : sw);
    irq_d = status_d | (tim_exp & tim_pm) | (pmode[0] ? sw : '0);
    tim_rd = fld == REG_T0_LOAD ? load_v[sel] :
             fld == REG_T0_CTRL ? 32'(ctrl_v[sel]) :
             fld == REG_T0_COUNT ? count_v[sel] : '0;
    rdata_d = !rd ? rdata_q :
              off < TIMER_SPAN ? tim_rd :
              off == REG_STATUS ? 32'(status_q) :
              off == REG_SW_MASKED ? 32'(irq_q) : '0;
  end

  // STATUS, interrupt line and read data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q <= '0;
      irq_q <= '0;
      rdata_q <= '0;
    end else begin
      status_q <= status_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign interrupt_req = irq_q;
  assign io_read_data = rdata_q;

  a_no_rw: assert property (@(posedge clk) disable iff (reset) !(io_read_en && io_write_en));

endmodule

// File: tb/tb_io_interrupt_generator.sv
// tb_io_interrupt_generator: directed and randomized checks against a schedule-based model
module tb_io_interrupt_generator;

  localparam logic [31:0] BASE = 32'hffff0200;

  logic        clk = 0;
  logic        reset = 1;
  logic        io_write_en = 0, io_read_en = 0;
  logic [31:0] io_address = 0, io_write_data = 0;
  logic [31:0] io_read_data;
  logic [15:0] interrupt_req;

  int n_tests = 0, n_fail = 0;

  io_interrupt_generator dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .interrupt_req (interrupt_req)
  );

  always #5 clk = ~clk;

  // Model: each enabled timer is described by the absolute cycle of its next expiry
  logic [31:0] m_load[2], m_frz[2];
  bit          m_en[2], m_per[2], m_pm[2];
  longint      m_exp[2];
  longint      cyc, n;
  logic [15:0] m_status, m_pulse, lvl, pls, msw, mack;
  logic [31:0] m_rd;
  logic [5:0]  moff;
  bit          mwr, mrd, swp, ctl_w;

  function automatic logic [31:0] m_count(int t);
    return (m_en[t] && m_exp[t] >= 0) ? 32'(m_exp[t] - cyc) : m_frz[t];
  endfunction

  function automatic logic [31:0] model_read(logic [5:0] o);
    int t, f;
    if (o < 6'h30) begin
      t = int'(o) / 12;
      f = int'(o) % 12;
      if (t >= 2) return 0;
      case (f)
        0: return m_load[t];
        4: return {29'd0, m_pm[t], m_per[t], m_en[t]};
        8: return m_count(t);
        default: return 0;
      endcase
    end
    if (o == 6'h30) return {16'd0, m_status};
    if (o == 6'h3C) return {16'd0, m_status | m_pulse};
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    if (reset) begin
      for (int t = 0; t < 2; t++) begin
        m_load[t] = 0; m_frz[t] = 0; m_en[t] = 0; m_per[t] = 0; m_pm[t] = 0; m_exp[t] = -1;
      end
      m_status = 0; m_pulse = 0; m_rd = 0; cyc = 0;
    end else begin
      n = cyc + 1;
      moff = io_address[5:0];
      mwr = io_write_en && io_address[31:6] == BASE[31:6];
      mrd = io_read_en && io_address[31:6] == BASE[31:6];
      if (mrd) m_rd = model_read(moff);
      swp = m_pm[0];
      lvl = 0; pls = 0;
      for (int t = 0; t < 2; t++) begin
        ctl_w = mwr && moff == 6'(12 * t + 4);
        if (m_en[t] && m_exp[t] == n && !ctl_w) begin
          if (m_pm[t]) pls[t] = 1'b1; else lvl[t] = 1'b1;
          if (m_per[t]) m_exp[t] = m_load[t] != 0 ? n + longint'(m_load[t]) : -1;
          else m_en[t] = 0;
          m_frz[t] = 0;
        end
        if (mwr && moff == 6'(12 * t)) m_load[t] = io_write_data;
        if (ctl_w) begin
          if (!io_write_data[0]) m_frz[t] = m_count(t);
          {m_pm[t], m_per[t], m_en[t]} = io_write_data[2:0];
          if (m_en[t]) begin
            m_exp[t] = m_load[t] != 0 ? n + longint'(m_load[t]) : -1;
            m_frz[t] = 0;
          end
        end
      end
      msw = (mwr && moff == 6'h38) ? io_write_data[15:0] & 16'hFFFC : 16'h0;
      mack = (mwr && moff == 6'h34) ? io_write_data[15:0] : 16'h0;
      m_status = (m_status & ~mack) | lvl | (swp ? 16'h0 : msw);
      m_pulse = pls | (swp ? msw : 16'h0);
      cyc = n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of both outputs against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("irq_model", 32'(interrupt_req), 32'(m_status | m_pulse));
      chk("rdata_model", io_read_data, m_rd);
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] d);
    io_write_en = 1; io_address = addr; io_write_data = d;
    @(posedge clk); #1;
    io_write_en = 0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    io_read_en = 1; io_address = addr;
    @(posedge clk); #1;
    io_read_en = 0;
    d = io_read_data;
  endtask

  task automatic wr(input logic [5:0] o, input logic [31:0] d);
    bus_write(BASE + 32'(o), d);
  endtask

  task automatic rd(input logic [5:0] o, output logic [31:0] d);
    bus_read(BASE + 32'(o), d);
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  logic [31:0] d;
  int          op;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("reset_irq", 32'(interrupt_req), 0);
    chk("reset_rdata", io_read_data, 0);

    // one-shot level timer0, L=5
    wr(6'h00, 5); wr(6'h04, 1);
    idle(4); chk("t0_before", 32'(interrupt_req[0]), 0);
    idle(1); chk("t0_rise", 32'(interrupt_req[0]), 1);
    rd(6'h08, d); chk("t0_count0", d, 0);
    rd(6'h04, d); chk("t0_ctrl0", d, 0);
    wr(6'h34, 1); chk("t0_acked", 32'(interrupt_req[0]), 0);
    idle(10); chk("t0_no_more", 32'(interrupt_req), 0);

    // periodic pulse timer1, L=3
    wr(6'h0C, 3); wr(6'h10, 7);
    idle(2); chk("t1_e2", 32'(interrupt_req[1]), 0);
    idle(1); chk("t1_e3", 32'(interrupt_req[1]), 1);
    idle(1); chk("t1_e4", 32'(interrupt_req[1]), 0);
    idle(2); chk("t1_e6", 32'(interrupt_req[1]), 1);
    idle(3); chk("t1_e9", 32'(interrupt_req[1]), 1);
    rd(6'h30, d); chk("t1_status", d, 0);
    wr(6'h10, 0);
    idle(4);

    // LOAD=0 stalls, then L=2
    wr(6'h00, 0); wr(6'h04, 1);
    idle(100); chk("stall_irq", 32'(interrupt_req), 0);
    rd(6'h08, d); chk("stall_count", d, 0);
    wr(6'h00, 2); wr(6'h04, 1);
    idle(1); chk("l2_e1", 32'(interrupt_req[0]), 0);
    idle(1); chk("l2_e2", 32'(interrupt_req[0]), 1);
    wr(6'h34, 1);

    // expiry and ACK in the same cycle: set wins
    wr(6'h00, 4); wr(6'h04, 1);
    idle(3); wr(6'h34, 1);
    chk("race_irq", 32'(interrupt_req[0]), 1);
    rd(6'h30, d); chk("race_status", d, 1);
    wr(6'h34, 1);

    // LOAD rewritten mid-count: current period unaffected
    wr(6'h00, 4); wr(6'h04, 3); wr(6'h00, 9);
    idle(2); chk("ld_e3", 32'(interrupt_req[0]), 0);
    idle(1); chk("ld_e4", 32'(interrupt_req[0]), 1);
    wr(6'h34, 1); chk("ld_ack", 32'(interrupt_req[0]), 0);
    idle(7); chk("ld_e12", 32'(interrupt_req[0]), 0);
    idle(1); chk("ld_e13", 32'(interrupt_req[0]), 1);
    wr(6'h04, 0); wr(6'h34, 1);

    // software sources
    wr(6'h38, 32'h10); chk("sw_set", 32'(interrupt_req), 32'h10);
    idle(3); chk("sw_hold", 32'(interrupt_req), 32'h10);
    wr(6'h38, 32'h3); chk("sw_lowbits", 32'(interrupt_req), 32'h10);
    rd(6'h3C, d); chk("sw_masked", d, 32'h10);
    wr(6'h34, 32'h10); chk("sw_ack", 32'(interrupt_req), 0);
    wr(6'h04, 4);
    wr(6'h38, 32'h20); chk("sw_pulse", 32'(interrupt_req), 32'h20);
    idle(1); chk("sw_pulse_end", 32'(interrupt_req), 0);
    rd(6'h30, d); chk("sw_pulse_status", d, 0);
    wr(6'h04, 0);

    // async reset mid-count
    wr(6'h00, 5); wr(6'h04, 1); rd(6'h00, d);
    idle(2);
    #2 reset = 1;
    #1 chk("arst_irq", 32'(interrupt_req), 0);
    chk("arst_rdata", io_read_data, 0);
    @(posedge clk); #1 reset = 0;
    idle(10); chk("arst_noirq", 32'(interrupt_req), 0);
    rd(6'h00, d); chk("arst_load", d, 0);
    rd(6'h04, d); chk("arst_ctrl", d, 0);
    rd(6'h08, d); chk("arst_count", d, 0);
    rd(6'h30, d); chk("arst_status", d, 0);

    // randomized traffic
    for (int k = 0; k < 2500; k++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: idle(1);
        3: wr(6'(12 * $urandom_range(0, 1)), $urandom_range(0, 6));
        4: wr(6'(12 * $urandom_range(0, 1) + 4), $urandom_range(0, 7));
        5: wr(6'h34, $urandom);
        6: wr(6'h38, $urandom & $urandom);
        7: rd(6'(4 * $urandom_range(0, 15)), d);
        8: wr(6'(4 * $urandom_range(0, 15)), $urandom_range(0, 7));
        default: if ($urandom_range(0, 1) != 0) bus_write(BASE + 32'h40 + 32'(4 * $urandom_range(0, 15)), $urandom_range(0, 7));
                 else bus_read(BASE - 32'h4, d);
      endcase
    end
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
